// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and the fetch-stage state encoding.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: captures the fetched word with its PC, or squashes to a NOP bubble.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc4_q;

  // A flush only clears valid/instr; the PC fields keep their last fetched values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0;
      pc4_q   <= 32'h0;
    end else if (en_i) begin
      if (flush_i) begin
        valid_q <= 1'b0;
        instr_q <= NOP_INSTR;
      end else begin
        valid_q <= 1'b1;
        instr_q <= instr_i;
        pc_q    <= pc_i;
        pc4_q   <= pc_i + WORD_BYTES;
      end
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS IF stage: owns the PC, handles stall/redirect/halt and feeds the IF/ID register.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 1064,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  output logic             if_id_valid,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_pc4,
  output logic             halted,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

  fetch_state_e     state_q;
  logic [31:0]      pc_q;
  logic [31:0]      pc_d;
  logic             halted_q;
  logic             misalignErr_q;
  logic [CNT_W-1:0] fetchCount_q;
  logic [CNT_W-1:0] fetchCount_d;

  logic outOfRange;
  logic redirectAligned;
  logic isHalt;
  logic regEnable;
  logic regFlush;

  assign outOfRange      = pc_q > LAST_PC;
  assign redirectAligned = redirect_pc[1:0] == 2'b00;
  assign isHalt          = state_q == FETCH_HALT;
  assign pc_d            = pc_q + WORD_BYTES;
  assign fetchCount_d    = fetchCount_q + CNT_W'(1);

  // Redirect beats stall; an un-stalled out-of-range fetch squashes instead of loading.
  assign regEnable = ~stall | redirect_valid | isHalt;
  assign regFlush  = redirect_valid | isHalt | outOfRange;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= FETCH_RUN;
      pc_q          <= RESET_PC;
      halted_q      <= 1'b0;
      misalignErr_q <= 1'b0;
      fetchCount_q  <= '0;
    end else begin
      case (state_q)
        FETCH_RUN: begin
          if (redirect_valid) begin
            if (redirectAligned) begin
              pc_q <= redirect_pc;
            end else begin
              misalignErr_q <= 1'b1;
              halted_q      <= 1'b1;
              state_q       <= FETCH_HALT;
            end
          end else if (!stall) begin
            if (outOfRange) begin
              halted_q <= 1'b1;
              state_q  <= FETCH_HALT;
            end else begin
              pc_q         <= pc_d;
              fetchCount_q <= fetchCount_d;
            end
          end
        end
        FETCH_HALT: begin
          if (redirect_valid) begin
            if (redirectAligned) begin
              pc_q     <= redirect_pc;
              halted_q <= 1'b0;
              state_q  <= FETCH_RUN;
            end else begin
              misalignErr_q <= 1'b1;
            end
          end
        end
        default: state_q <= FETCH_HALT;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clock   (clock),
    .reset_n (reset_n),
    .en_i    (regEnable),
    .flush_i (regFlush),
    .instr_i (imem_data),
    .pc_i    (pc_q),
    .valid_o (if_id_valid),
    .instr_o (if_id_instr),
    .pc_o    (if_id_pc),
    .pc4_o   (if_id_pc4)
  );

  assign imem_addr    = pc_q;
  assign halted       = halted_q;
  assign misalign_err = misalignErr_q;
  assign fetch_count  = fetchCount_q;

  pcWordAligned: assert property (@(posedge clock) disable iff (!reset_n) pc_q[1:0] == 2'b00);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, mid-run reset, then random traffic vs a reference model.
module tb_instruction_fetch_unit;

  localparam int MEM_WORDS = 266;

  logic        clock;
  logic        resetN;
  logic        stall;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic        ifIdValid;
  logic [31:0] ifIdInstr;
  logic [31:0] ifIdPc;
  logic [31:0] ifIdPc4;
  logic        halted;
  logic        misalignErr;
  logic [15:0] fetchCount;

  logic [31:0] mem [0:MEM_WORDS-1];

  int checks = 0;
  int errors = 0;

  // Reference model state: what the fetch stage should look like after each edge.
  logic [31:0] mPc;
  logic        mHalt;
  logic        mMis;
  logic        mValid;
  logic [31:0] mInstr;
  logic [31:0] mIpc;
  logic [31:0] mIpc4;
  logic [15:0] mCnt;

  typedef struct {
    logic        st;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expInstr;
    logic [31:0] expPc;
    logic        expHalted;
    logic        expMis;
    logic [15:0] expCount;
  } vec_t;

  vec_t vecs [20];

  instruction_fetch_unit #(
    .RESET_PC   (32'h0),
    .IMEM_BYTES (1064),
    .CNT_W      (16)
  ) dut (
    .clock          (clock),
    .reset_n        (resetN),
    .stall          (stall),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc),
    .imem_addr      (imemAddr),
    .imem_data      (imemData),
    .if_id_valid    (ifIdValid),
    .if_id_instr    (ifIdInstr),
    .if_id_pc       (ifIdPc),
    .if_id_pc4      (ifIdPc4),
    .halted         (halted),
    .misalign_err   (misalignErr),
    .fetch_count    (fetchCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] memRead(input logic [31:0] addr);
    if (addr <= 32'd1060 && addr[1:0] == 2'b00) return mem[addr >> 2];
    return 32'hFFFF_FFFF;
  endfunction

  assign imemData = memRead(imemAddr);

  function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] rpc,
                              input logic [31:0] addr, input logic v, input logic [31:0] instr,
                              input logic [31:0] pc, input logic h, input logic mis,
                              input logic [15:0] cnt);
    vec_t r;
    r.st = st; r.rv = rv; r.rpc = rpc; r.expAddr = addr; r.expValid = v;
    r.expInstr = instr; r.expPc = pc; r.expHalted = h; r.expMis = mis; r.expCount = cnt;
    return r;
  endfunction

  task automatic modelReset();
    mPc = 32'h0; mHalt = 1'b0; mMis = 1'b0; mValid = 1'b0;
    mInstr = 32'h0; mIpc = 32'h0; mIpc4 = 32'h0; mCnt = 16'h0;
  endtask

  // One rising edge of the fetch stage, following the priority rules directly.
  task automatic modelStep(input logic st, input logic rv, input logic [31:0] rpc);
    if (!mHalt) begin
      if (rv) begin
        if (rpc % 4 != 0) begin
          mMis = 1'b1;
          mHalt = 1'b1;
        end else begin
          mPc = rpc;
        end
        mValid = 1'b0;
        mInstr = 32'h0;
      end else if (!st) begin
        if (mPc > 32'd1060) begin
          mHalt = 1'b1;
          mValid = 1'b0;
          mInstr = 32'h0;
        end else begin
          mInstr = memRead(mPc);
          mIpc = mPc;
          mIpc4 = mPc + 32'd4;
          mValid = 1'b1;
          mPc = mPc + 32'd4;
          mCnt = mCnt + 16'd1;
        end
      end
    end else if (rv) begin
      if (rpc % 4 != 0) begin
        mMis = 1'b1;
      end else begin
        mPc = rpc;
        mHalt = 1'b0;
      end
    end
  endtask

  // Drive inputs, take one edge, advance the model, then settle before sampling.
  task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rpc);
    stall = st;
    redirectValid = rv;
    redirectPc = rpc;
    @(posedge clock);
    modelStep(st, rv, rpc);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [31:0] addr, input logic v,
                          input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pc4,
                          input logic h, input logic mis, input logic [15:0] cnt);
    checkOutput({tag, ".imem_addr"}, imemAddr, addr);
    checkOutput({tag, ".if_id_valid"}, {31'b0, ifIdValid}, {31'b0, v});
    checkOutput({tag, ".if_id_instr"}, ifIdInstr, instr);
    checkOutput({tag, ".if_id_pc"}, ifIdPc, pc);
    checkOutput({tag, ".if_id_pc4"}, ifIdPc4, pc4);
    checkOutput({tag, ".halted"}, {31'b0, halted}, {31'b0, h});
    checkOutput({tag, ".misalign_err"}, {31'b0, misalignErr}, {31'b0, mis});
    checkOutput({tag, ".fetch_count"}, {16'b0, fetchCount}, {16'b0, cnt});
  endtask

  task automatic checkModel(input string tag);
    checkAll(tag, mPc, mValid, mInstr, mIpc, mIpc4, mHalt, mMis, mCnt);
  endtask

  initial begin
    logic [31:0] rpc;
    int sel;

    // Memory image: word at byte address A holds A0000000+A, except the first two words.
    for (int w = 0; w < MEM_WORDS; w++) mem[w] = 32'hA000_0000 + 32'(w * 4);
    mem[0] = 32'h8C00_0000;
    mem[1] = 32'h8C01_0001;

    // Directed vectors from reset: stall at 12, redirect+stall at 20, misaligned redirect, end-of-memory halt.
    vecs[0]  = mk(0, 0, 0,        4,    1, 32'h8C00_0000, 0,    0, 0, 1);
    vecs[1]  = mk(0, 0, 0,        8,    1, 32'h8C01_0001, 4,    0, 0, 2);
    vecs[2]  = mk(0, 0, 0,        12,   1, 32'hA000_0008, 8,    0, 0, 3);
    vecs[3]  = mk(1, 0, 0,        12,   1, 32'hA000_0008, 8,    0, 0, 3);
    vecs[4]  = mk(1, 0, 0,        12,   1, 32'hA000_0008, 8,    0, 0, 3);
    vecs[5]  = mk(1, 0, 0,        12,   1, 32'hA000_0008, 8,    0, 0, 3);
    vecs[6]  = mk(0, 0, 0,        16,   1, 32'hA000_000C, 12,   0, 0, 4);
    vecs[7]  = mk(0, 0, 0,        20,   1, 32'hA000_0010, 16,   0, 0, 5);
    vecs[8]  = mk(1, 1, 40,       40,   0, 32'h0,         16,   0, 0, 5);
    vecs[9]  = mk(0, 0, 0,        44,   1, 32'hA000_0028, 40,   0, 0, 6);
    vecs[10] = mk(0, 1, 32'h22,   44,   0, 32'h0,         40,   1, 1, 6);
    vecs[11] = mk(1, 0, 0,        44,   0, 32'h0,         40,   1, 1, 6);
    vecs[12] = mk(0, 1, 8,        8,    0, 32'h0,         40,   0, 1, 6);
    vecs[13] = mk(0, 0, 0,        12,   1, 32'hA000_0008, 8,    0, 1, 7);
    vecs[14] = mk(0, 1, 1056,     1056, 0, 32'h0,         8,    0, 1, 7);
    vecs[15] = mk(0, 0, 0,        1060, 1, 32'hA000_0420, 1056, 0, 1, 8);
    vecs[16] = mk(0, 0, 0,        1064, 1, 32'hA000_0424, 1060, 0, 1, 9);
    vecs[17] = mk(0, 0, 0,        1064, 0, 32'h0,         1060, 1, 1, 9);
    vecs[18] = mk(1, 0, 0,        1064, 0, 32'h0,         1060, 1, 1, 9);
    vecs[19] = mk(0, 0, 0,        1064, 0, 32'h0,         1060, 1, 1, 9);

    resetN = 1'b0;
    stall = 1'b0;
    redirectValid = 1'b0;
    redirectPc = 32'h0;
    modelReset();

    #2;
    checkAll("reset", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0);

    @(negedge clock);
    resetN = 1'b1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].st, vecs[i].rv, vecs[i].rpc);
      checkAll($sformatf("vec%0d", i), vecs[i].expAddr, vecs[i].expValid, vecs[i].expInstr,
               vecs[i].expPc, vecs[i].expPc + 32'd4, vecs[i].expHalted, vecs[i].expMis,
               vecs[i].expCount);
    end

    // Recover from halt, run a little, then drop reset between edges.
    applyStimulus(0, 1, 32'h0);
    applyStimulus(0, 0, 32'h0);
    applyStimulus(1, 0, 32'h0);
    #2;
    resetN = 1'b0;
    #1;
    checkAll("asyncReset", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0);
    modelReset();
    @(negedge clock);
    stall = 1'b0;
    redirectValid = 1'b0;
    resetN = 1'b1;
    applyStimulus(0, 0, 32'h0);
    checkAll("postReset", 32'h4, 1'b1, 32'h8C00_0000, 32'h0, 32'h4, 1'b0, 1'b0, 16'h1);

    // Random stall/redirect traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      sel = int'($urandom_range(0, 7));
      if (sel == 0)
        rpc = 32'($urandom_range(0, MEM_WORDS - 1) * 4) + 32'($urandom_range(1, 3));
      else if (sel == 1)
        rpc = 32'($urandom_range(258, 268) * 4);
      else
        rpc = 32'($urandom_range(0, MEM_WORDS - 1) * 4);
      applyStimulus(($urandom % 4) == 0, ($urandom % 8) == 0, rpc);
      checkModel($sformatf("rand%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
